// File: rtl/pll_lock_supervisor.sv
// PLL bring-up and lock supervisor: holds PLLs in reset, debounces lock, releases core reset, retries on loss.
// Optional WAIT_LOCK acquisition timeout is enabled by defining PLL_SUP_LOCK_TIMEOUT_EN.
module pll_lock_supervisor #(
  parameter int unsigned N_PLL         = 1,
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned STABLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT  = 65536,
  parameter int unsigned MAX_RETRIES   = 3,
  parameter int unsigned CNT_W         = 17,
  localparam int unsigned RC_W = (MAX_RETRIES == 0) ? 1 : $clog2(MAX_RETRIES + 1)
) (
  input  logic             REFERENCECLK,
  input  logic             RESET,
  input  logic [N_PLL-1:0] LOCK,
  input  logic             CLEAR_FAULT,
  output logic             PLL_RESETB,
  output logic             CORE_RESETN,
  output logic             READY,
  output logic             FAULT,
  output logic [RC_W-1:0]  RETRY_COUNT,
  output logic [2:0]       STATE
);

`ifdef PLL_SUP_LOCK_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RC_W-1:0]   rc_q, rc_d;
  logic [N_PLL-1:0]  lock_meta_q, lock_sync_q;
  logic              pll_resetb_q, core_resetn_q, ready_q, fault_q;
  logic              locked;
  logic              retry;

  assign locked = &lock_sync_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rc_d    = rc_q;
    retry   = 1'b0;
    case (state_q)
      S_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_WAIT_LOCK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT_LOCK: begin
        if (locked) begin
          cnt_d   = '0;
          state_d = S_STABLE;
        end else if (TIMEOUT_EN) begin
          if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) retry = 1'b1;
          else                                   cnt_d = cnt_q + 1'b1;
        end
      end
      S_STABLE: begin
        // Loss of lock is checked first so it wins over a completing debounce count.
        if (!locked) begin
          cnt_d   = '0;
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
          cnt_d   = '0;
          rc_d    = '0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (!locked) retry = 1'b1;
      end
      S_FAULT: begin
        if (CLEAR_FAULT) begin
          cnt_d   = '0;
          rc_d    = '0;
          state_d = S_HOLD;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_HOLD;
      end
    endcase

    if (retry) begin
      cnt_d = '0;
      if (rc_q == RC_W'(MAX_RETRIES)) begin
        state_d = S_FAULT;
      end else begin
        rc_d    = rc_q + 1'b1;
        state_d = S_HOLD;
      end
    end
  end

  // Outputs are registered from the next state so they move on the same edge as STATE.
  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= S_HOLD;
      cnt_q         <= '0;
      rc_q          <= '0;
      lock_meta_q   <= '0;
      lock_sync_q   <= '0;
      pll_resetb_q  <= 1'b0;
      core_resetn_q <= 1'b0;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rc_q          <= rc_d;
      lock_meta_q   <= LOCK;
      lock_sync_q   <= lock_meta_q;
      pll_resetb_q  <= (state_d == S_WAIT_LOCK) || (state_d == S_STABLE) || (state_d == S_RUN);
      core_resetn_q <= (state_d == S_RUN);
      ready_q       <= (state_d == S_RUN);
      fault_q       <= (state_d == S_FAULT);
    end
  end

  assign PLL_RESETB  = pll_resetb_q;
  assign CORE_RESETN = core_resetn_q;
  assign READY       = ready_q;
  assign FAULT       = fault_q;
  assign RETRY_COUNT = rc_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed vector table, corner sequences, random vs reference model.
module tb_pll_lock_supervisor;

  localparam int unsigned A_HOLD = 16, A_STAB = 8, A_TMO = 100, A_MAXR = 2;
  localparam int unsigned B_HOLD = 4,  B_STAB = 3, B_TMO = 20,  B_MAXR = 0;

`ifdef PLL_SUP_LOCK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk     = 1'b0;
  logic       rst_a_n = 1'b1;
  logic       rst_b_n = 1'b1;
  logic [2:0] lock_a  = '0;
  logic [2:0] lock_b  = '0;
  logic       clr_a   = 1'b0;
  logic       clr_b   = 1'b0;

  logic       prb_a, core_a, rdy_a, flt_a;
  logic [1:0] rc_a;
  logic [2:0] st_a;
  logic       prb_b, core_b, rdy_b, flt_b;
  logic [0:0] rc_b;
  logic [2:0] st_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pll_lock_supervisor #(
    .N_PLL(3), .HOLD_CYCLES(A_HOLD), .STABLE_CYCLES(A_STAB),
    .LOCK_TIMEOUT(A_TMO), .MAX_RETRIES(A_MAXR), .CNT_W(17)
  ) u_dut_a (
    .REFERENCECLK(clk), .RESET(rst_a_n), .LOCK(lock_a), .CLEAR_FAULT(clr_a),
    .PLL_RESETB(prb_a), .CORE_RESETN(core_a), .READY(rdy_a), .FAULT(flt_a),
    .RETRY_COUNT(rc_a), .STATE(st_a)
  );

  pll_lock_supervisor #(
    .N_PLL(3), .HOLD_CYCLES(B_HOLD), .STABLE_CYCLES(B_STAB),
    .LOCK_TIMEOUT(B_TMO), .MAX_RETRIES(B_MAXR), .CNT_W(5)
  ) u_dut_b (
    .REFERENCECLK(clk), .RESET(rst_b_n), .LOCK(lock_b), .CLEAR_FAULT(clr_b),
    .PLL_RESETB(prb_b), .CORE_RESETN(core_b), .READY(rdy_b), .FAULT(flt_b),
    .RETRY_COUNT(rc_b), .STATE(st_b)
  );

  // Reference model: phase number plus a countdown of edges remaining in that phase.
  typedef struct {
    int         ph;
    int         left;
    int         rc;
    logic [2:0] s1;
    logic [2:0] s2;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset(input int hold);
    mdl_t m;
    m.ph = 0; m.left = hold; m.rc = 0; m.s1 = '0; m.s2 = '0;
    return m;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t m, input logic [2:0] lk, input logic clr,
                                    input int hold, input int stab, input int tmo, input int maxr);
    mdl_t n;
    bit   locked;
    bit   retry;
    n      = m;
    locked = (m.s2 == 3'b111);
    retry  = 1'b0;
    n.s1   = lk;
    n.s2   = m.s1;
    case (m.ph)
      0: begin
        n.left = m.left - 1;
        if (n.left == 0) begin n.ph = 1; n.left = tmo; end
      end
      1: begin
        if (locked) begin
          n.ph = 2; n.left = stab;
        end else if (TO_EN) begin
          n.left = m.left - 1;
          if (n.left == 0) retry = 1'b1;
        end
      end
      2: begin
        if (!locked) begin
          n.ph = 1; n.left = tmo;
        end else begin
          n.left = m.left - 1;
          if (n.left == 0) begin n.ph = 3; n.rc = 0; end
        end
      end
      3: if (!locked) retry = 1'b1;
      default: if (clr) begin n.ph = 0; n.rc = 0; n.left = hold; end
    endcase
    if (retry) begin
      if (m.rc == maxr) n.ph = 4;
      else begin n.ph = 0; n.rc = m.rc + 1; n.left = hold; end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_a_n)
    if (!rst_a_n) ma <= mdl_reset(A_HOLD);
    else          ma <= mdl_next(ma, lock_a, clr_a, A_HOLD, A_STAB, A_TMO, A_MAXR);

  always @(posedge clk or negedge rst_b_n)
    if (!rst_b_n) mb <= mdl_reset(B_HOLD);
    else          mb <= mdl_next(mb, lock_b, clr_b, B_HOLD, B_STAB, B_TMO, B_MAXR);

  // Packed observation: {STATE, PLL_RESETB, CORE_RESETN, READY, FAULT, RETRY_COUNT[1:0]}
  function automatic logic [8:0] expv(input int ph, input int rc);
    logic [2:0] s;
    s = 3'(ph);
    return {s, (ph >= 1 && ph <= 3), (ph == 3), (ph == 3), (ph == 4), 2'(rc)};
  endfunction

  function automatic logic [8:0] act_a();
    return {st_a, prb_a, core_a, rdy_a, flt_a, rc_a};
  endfunction

  function automatic logic [8:0] act_b();
    return {st_b, prb_b, core_b, rdy_b, flt_b, 1'b0, rc_b};
  endfunction

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got st=%0d prb=%b core=%b rdy=%b flt=%b rc=%0d, want st=%0d prb=%b core=%b rdy=%b flt=%b rc=%0d",
               nm, act[8:6], act[5], act[4], act[3], act[2], act[1:0],
               exp[8:6], exp[5], exp[4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0] lock;
    int         n;
    logic [2:0] st;
    logic       prb;
    logic       rdy;
    logic [1:0] rc;
  } vec_t;

  initial begin
    vec_t tbl[22];
    logic [8:0] want;
    // edge numbers after reset release are noted per row
    tbl[0]  = '{3'b000, 15, 3'd0, 1'b0, 1'b0, 2'd0}; // 15
    tbl[1]  = '{3'b000,  1, 3'd1, 1'b1, 1'b0, 2'd0}; // 16
    tbl[2]  = '{3'b011, 24, 3'd1, 1'b1, 1'b0, 2'd0}; // 40
    tbl[3]  = '{3'b111,  2, 3'd1, 1'b1, 1'b0, 2'd0}; // 42
    tbl[4]  = '{3'b111,  1, 3'd2, 1'b1, 1'b0, 2'd0}; // 43
    tbl[5]  = '{3'b111,  7, 3'd2, 1'b1, 1'b0, 2'd0}; // 50
    tbl[6]  = '{3'b111,  1, 3'd3, 1'b1, 1'b1, 2'd0}; // 51
    tbl[7]  = '{3'b000,  2, 3'd3, 1'b1, 1'b1, 2'd0}; // 53
    tbl[8]  = '{3'b000,  1, 3'd0, 1'b0, 1'b0, 2'd1}; // 54
    tbl[9]  = '{3'b111, 16, 3'd1, 1'b1, 1'b0, 2'd1}; // 70
    tbl[10] = '{3'b111,  1, 3'd2, 1'b1, 1'b0, 2'd1}; // 71
    tbl[11] = '{3'b111,  8, 3'd3, 1'b1, 1'b1, 2'd0}; // 79
    tbl[12] = '{3'b000,  1, 3'd3, 1'b1, 1'b1, 2'd0}; // 80
    tbl[13] = '{3'b111,  2, 3'd0, 1'b0, 1'b0, 2'd1}; // 82
    tbl[14] = '{3'b111, 16, 3'd1, 1'b1, 1'b0, 2'd1}; // 98
    tbl[15] = '{3'b111,  1, 3'd2, 1'b1, 1'b0, 2'd1}; // 99
    tbl[16] = '{3'b111,  4, 3'd2, 1'b1, 1'b0, 2'd1}; // 103
    tbl[17] = '{3'b000,  2, 3'd2, 1'b1, 1'b0, 2'd1}; // 105
    tbl[18] = '{3'b000,  1, 3'd1, 1'b1, 1'b0, 2'd1}; // 106
    tbl[19] = '{3'b111,  3, 3'd2, 1'b1, 1'b0, 2'd1}; // 109
    tbl[20] = '{3'b111,  5, 3'd2, 1'b1, 1'b0, 2'd1}; // 114
    tbl[21] = '{3'b000,  3, 3'd1, 1'b1, 1'b0, 2'd1}; // 117: loss beats debounce completion

    #1;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    lock_b  = 3'b111;
    @(negedge clk);
    chk("reset_a", act_a(), expv(0, 0));
    chk("reset_b", act_b(), expv(0, 0));

    // Instance B: zero retries, so a single lock loss in RUN faults.
    rst_b_n = 1'b1;
    edges(4); chk("b_wait", act_b(), expv(1, 0));
    edges(1); chk("b_stable", act_b(), expv(2, 0));
    edges(3); chk("b_run", act_b(), expv(3, 0));
    lock_b = 3'b000;
    edges(3); chk("b_fault", act_b(), expv(4, 0));
    lock_b = 3'b111;
    edges(5); chk("b_fault_sticky", act_b(), expv(4, 0));
    clr_b = 1'b1; edges(1); clr_b = 1'b0;
    chk("b_clear", act_b(), expv(0, 0));
    edges(4); chk("b_rewait", act_b(), expv(1, 0));
    edges(1); chk("b_restable", act_b(), expv(2, 0));
    edges(3); chk("b_rerun", act_b(), expv(3, 0));
    clr_b = 1'b1; edges(1); clr_b = 1'b0;
    chk("b_clear_ignored", act_b(), expv(3, 0));

    // Instance A: directed vector table.
    rst_a_n = 1'b1;
    for (int i = 0; i < 22; i++) begin
      lock_a = tbl[i].lock;
      edges(tbl[i].n);
      want = {tbl[i].st, tbl[i].prb, tbl[i].rdy, tbl[i].rdy, (tbl[i].st == 3'd4), tbl[i].rc};
      chk($sformatf("vec%0d", i), act_a(), want);
    end

    // Asynchronous reset in STABLE and in RUN.
    lock_a = 3'b111;
    edges(3); chk("a_stable_pre", act_a(), expv(2, 1));
    rst_a_n = 1'b0; #1;
    chk("a_rst_in_stable", act_a(), expv(0, 0));
    @(negedge clk); rst_a_n = 1'b1;
    edges(16); chk("a_restart_wait", act_a(), expv(1, 0));
    edges(1);  chk("a_restart_stable", act_a(), expv(2, 0));
    edges(8);  chk("a_restart_run", act_a(), expv(3, 0));
    rst_a_n = 1'b0; #1;
    chk("a_rst_in_run", act_a(), expv(0, 0));
    lock_a = 3'b000;
    @(negedge clk); rst_a_n = 1'b1;

`ifdef PLL_SUP_LOCK_TIMEOUT_EN
    edges(116); chk("a_to_retry1", act_a(), expv(0, 1));
    edges(116); chk("a_to_retry2", act_a(), expv(0, 2));
    edges(115); chk("a_to_lastwait", act_a(), expv(1, 2));
    edges(1);   chk("a_to_fault", act_a(), expv(4, 2));
    clr_a = 1'b1; edges(1); clr_a = 1'b0;
    chk("a_to_clear", act_a(), expv(0, 0));
`else
    edges(16);  chk("a_wait_entry", act_a(), expv(1, 0));
    edges(300); chk("a_wait_forever", act_a(), expv(1, 0));
`endif

    // Randomised run of both instances against the reference model.
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    lock_a  = '0;
    lock_b  = '0;
    @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      chk("rand_a", act_a(), expv(ma.ph, ma.rc));
      chk("rand_b", act_b(), expv(mb.ph, mb.rc));
      if ($urandom_range(0, 23) == 0)
        lock_a = ($urandom_range(0, 2) != 0) ? 3'b111 : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 11) == 0)
        lock_b = ($urandom_range(0, 2) != 0) ? 3'b111 : 3'($urandom_range(0, 7));
      clr_a = ($urandom_range(0, 49) == 0);
      clr_b = ($urandom_range(0, 29) == 0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
